// File: rtl/td4_seq_if.sv
// Run-control / decode bus between the td4 core and its sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; the core stalls purely through ce.
//
// Signals (master = core/debug side, slave = td4_seq):
//   instr[7:0]                  current instruction from ROM
//   pc[3:0]                     current program counter
//   alu_co                      adder carry out for the current instruction
//   run, step, halt             run-control commands
//   brk_adr[3:0], brk_valid     breakpoint address and arm
//   ce                          execute enable
//   select_a, select_b          data-selector control
//   load0..load3                load strobes for A, B, OUT, PC
//   carry                       registered carry flag
//   state[1:0]                  00=HALT 01=RUN 10=STEP
//   brk_hit                     sticky breakpoint-hit flag
//   instr_cnt[CNT_W-1:0]        saturating executed-instruction count
interface td4_seq_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       instr;
    logic [3:0]       pc;
    logic             alu_co;
    logic             run;
    logic             step;
    logic             halt;
    logic [3:0]       brk_adr;
    logic             brk_valid;
    logic             ce;
    logic             select_a;
    logic             select_b;
    logic             load0;
    logic             load1;
    logic             load2;
    logic             load3;
    logic             carry;
    logic [1:0]       state;
    logic             brk_hit;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output instr, pc, alu_co, run, step, halt, brk_adr, brk_valid,
        input  ce, select_a, select_b, load0, load1, load2, load3,
               carry, state, brk_hit, instr_cnt
    );

    modport slave (
        input  instr, pc, alu_co, run, step, halt, brk_adr, brk_valid,
        output ce, select_a, select_b, load0, load1, load2, load3,
               carry, state, brk_hit, instr_cnt
    );
endinterface

// File: rtl/td4_seq.sv
// td4 run-control and instruction-decode sequencer (HALT/RUN/STEP, carry, breakpoint).
// Latency: decode 0 cycles; carry, state and count update 1 cycle after a ce edge.
// Backpressure: the core stalls by ce=0; commands are sampled every edge, no handshake.
//
// Ports: clk, reset (async active-high), bus (td4_seq_if.slave; see td4_seq_if.sv).
// Optional feature: define TD4_SEQ_BRK_EN to enable breakpoint handling; without it
// brk_adr/brk_valid are ignored and brk_hit reads 0.
module td4_seq #(
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      reset,
    td4_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic             brk_hit_q, brk_hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brk_cyc;
    logic             ce;
`ifdef TD4_SEQ_BRK_EN
    // Set for the first RUN cycle so a resumed run steps over the breakpoint.
    logic             first_q, first_d;
`endif

    // Immediate field belongs to the datapath; the breakpoint inputs are only
    // consumed when the feature is built in.
    logic unused_inputs;
    assign unused_inputs = ^{bus.instr[3:0], bus.brk_adr, bus.brk_valid};

    always_comb begin
        brk_cyc = 1'b0;
`ifdef TD4_SEQ_BRK_EN
        brk_cyc = (state_q == ST_RUN) && !first_q && bus.brk_valid
                  && (bus.pc == bus.brk_adr);
`endif
    end

    // A breakpoint cycle suppresses execution of the instruction at brk_adr.
    assign ce = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !brk_cyc;

    always_comb begin
        state_d   = state_q;
        brk_hit_d = brk_hit_q;
`ifdef TD4_SEQ_BRK_EN
        first_d   = 1'b0;
`endif
        unique case (state_q)
            ST_HALT: begin
                // halt > step > run
                if (!bus.halt) begin
                    if (bus.step) begin
                        state_d   = ST_STEP;
                        brk_hit_d = 1'b0;
                    end else if (bus.run) begin
                        state_d   = ST_RUN;
                        brk_hit_d = 1'b0;
`ifdef TD4_SEQ_BRK_EN
                        first_d   = 1'b1;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (brk_cyc) begin
                    brk_hit_d = 1'b1;
                end
                if (bus.halt || brk_cyc) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        carry_d = ce ? bus.alu_co : carry_q;

        cnt_d = cnt_q;
        if (ce && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HALT;
            carry_q   <= 1'b0;
            brk_hit_q <= 1'b0;
            cnt_q     <= '0;
`ifdef TD4_SEQ_BRK_EN
            first_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            brk_hit_q <= brk_hit_d;
            cnt_q     <= cnt_d;
`ifdef TD4_SEQ_BRK_EN
            first_q   <= first_d;
`endif
        end
    end

    // Decode: selectors are free-running, load strobes only fire when committing.
    // JNC (1110) loads PC only with carry clear; JMP (1111) always loads.
    assign bus.select_a = bus.instr[4] | bus.instr[7];
    assign bus.select_b = bus.instr[5];
    assign bus.load0    = ce & ~bus.instr[7] & ~bus.instr[6];
    assign bus.load1    = ce & ~bus.instr[7] &  bus.instr[6];
    assign bus.load2    = ce &  bus.instr[7] & ~bus.instr[6];
    assign bus.load3    = ce &  bus.instr[7] &  bus.instr[6] & (bus.instr[4] | ~carry_q);

    assign bus.ce        = ce;
    assign bus.carry     = carry_q;
    assign bus.state     = state_q;
    assign bus.brk_hit   = brk_hit_q;
    assign bus.instr_cnt = cnt_q;

endmodule
